// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: opcodes, flag layout, stage state.
package cpu_pkg;

  localparam logic [3:0] OpAdd    = 4'h0;
  localparam logic [3:0] OpSub    = 4'h1;
  localparam logic [3:0] OpXor    = 4'h2;
  localparam logic [3:0] OpRed    = 4'h3;
  localparam logic [3:0] OpSll    = 4'h4;
  localparam logic [3:0] OpSra    = 4'h5;
  localparam logic [3:0] OpRor    = 4'h6;
  localparam logic [3:0] OpPaddsb = 4'h7;
  localparam logic [3:0] OpLw     = 4'h8;
  localparam logic [3:0] OpSw     = 4'h9;
  localparam logic [3:0] OpLhb    = 4'hA;
  localparam logic [3:0] OpLlb    = 4'hB;
  localparam logic [3:0] OpB      = 4'hC;
  localparam logic [3:0] OpBr     = 4'hD;
  localparam logic [3:0] OpPcs    = 4'hE;
  localparam logic [3:0] OpHlt    = 4'hF;

  // Bit positions inside the {N,V,Z} flag vector
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagZ = 0;

  typedef enum logic {StRun, StHalt} state_e;

  // Which flag bits an opcode is allowed to update
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OpAdd, OpSub: begin
        m[FlagN] = 1'b1;
        m[FlagV] = 1'b1;
        m[FlagZ] = 1'b1;
      end
      OpXor, OpSll, OpSra, OpRor: m[FlagZ] = 1'b1;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side inputs and MEM-side registered outputs of the EX/MEM pipeline register.
interface ex_mem_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
);
  logic          ex_vld_i;
  logic [3:0]    ex_opcode_i;
  logic [DW-1:0] ex_alu_out_i;
  logic [2:0]    ex_alu_flag_i;
  logic [DW-1:0] ex_store_data_i;
  logic [RW-1:0] ex_rd_i;
  logic          ex_regwrite_i;
  logic          ex_memread_i;
  logic          ex_memwrite_i;

  logic          mem_vld_o;
  logic [DW-1:0] mem_alu_out_o;
  logic [DW-1:0] mem_store_data_o;
  logic [RW-1:0] mem_rd_o;
  logic          mem_regwrite_o;
  logic          mem_memread_o;
  logic          mem_memwrite_o;

  modport master (
    output ex_vld_i, ex_opcode_i, ex_alu_out_i, ex_alu_flag_i, ex_store_data_i, ex_rd_i,
           ex_regwrite_i, ex_memread_i, ex_memwrite_i,
    input  mem_vld_o, mem_alu_out_o, mem_store_data_o, mem_rd_o, mem_regwrite_o,
           mem_memread_o, mem_memwrite_o
  );

  modport slave (
    input  ex_vld_i, ex_opcode_i, ex_alu_out_i, ex_alu_flag_i, ex_store_data_i, ex_rd_i,
           ex_regwrite_i, ex_memread_i, ex_memwrite_i,
    output mem_vld_o, mem_alu_out_o, mem_store_data_o, mem_rd_o, mem_regwrite_o,
           mem_memread_o, mem_memwrite_o
  );
endinterface

// File: rtl/flag_reg.sv
// 3-bit flag register with per-bit write mask; exposes current and next value.
module flag_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] we_i,
  input  logic [2:0] d_i,
  output logic [2:0] q_o,
  output logic [2:0] q_next_o
);

  logic [2:0] q_q;

  // Masked bits take new data, the rest hold
  always_comb begin
    q_next_o = (we_i & d_i) | (~we_i & q_q);
  end

  // Flag state; an all-zero mask makes this a hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 3'b000;
    end else begin
      q_q <= q_next_o;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register, architectural flag commit and sticky halt tracking.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 flush_i,
  ex_mem_stage_if.slave        bus,
  output logic [2:0]           flag_o,
  output logic [2:0]           flag_fwd_o,
  output logic                 halted_o
);

  state_e        state_q, state_d;
  logic          cap;
  logic          load;
  logic          is_hlt;
  logic [2:0]    flag_we;

  logic          vld_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] store_q;
  logic [RW-1:0] rd_q;
  logic          regwrite_q;
  logic          memread_q;
  logic          memwrite_q;

  assign is_hlt = (bus.ex_opcode_i == OpHlt);
  // Flush wins over stall, so the register loads (a bubble) when either lets it
  assign load   = ~stall_i | flush_i;
  assign cap    = bus.ex_vld_i & ~flush_i & ~stall_i & (state_q == StRun);

  // Halt is sticky; only reset returns to run
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (cap && is_hlt) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // EX/MEM register; HLT retires as a valid slot with no side effects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= 1'b0;
      alu_q      <= '0;
      store_q    <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else if (load) begin
      vld_q      <= cap;
      alu_q      <= bus.ex_alu_out_i;
      store_q    <= bus.ex_store_data_i;
      rd_q       <= bus.ex_rd_i;
      regwrite_q <= bus.ex_regwrite_i & cap & ~is_hlt & (bus.ex_rd_i != '0);
      memread_q  <= bus.ex_memread_i & cap & ~is_hlt;
      memwrite_q <= bus.ex_memwrite_i & cap & ~is_hlt;
    end
  end

  // Only captured instructions may touch the flags
  always_comb begin
    flag_we = cap ? flag_mask(bus.ex_opcode_i) : 3'b000;
  end

  flag_reg u_flag_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (flag_we),
    .d_i      (bus.ex_alu_flag_i),
    .q_o      (flag_o),
    .q_next_o (flag_fwd_o)
  );

  assign bus.mem_vld_o        = vld_q;
  assign bus.mem_alu_out_o    = alu_q;
  assign bus.mem_store_data_o = store_q;
  assign bus.mem_rd_o         = rd_q;
  assign bus.mem_regwrite_o   = regwrite_q;
  assign bus.mem_memread_o    = memread_q;
  assign bus.mem_memwrite_o   = memwrite_q;
  assign halted_o             = (state_q == StHalt);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage.
module tb_ex_mem_stage;
  import cpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       stall_i;
  logic       flush_i;
  logic [2:0] flag_o;
  logic [2:0] flag_fwd_o;
  logic       halted_o;

  int tests;
  int fails;

  ex_mem_stage_if #(.DW(16), .RW(4)) bus ();

  ex_mem_stage #(.DW(16), .RW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .bus        (bus),
    .flag_o     (flag_o),
    .flag_fwd_o (flag_fwd_o),
    .halted_o   (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] op, input logic [15:0] alu,
                       input logic [2:0] flg, input logic [15:0] sd, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic mw);
    bus.ex_vld_i        = vld;
    bus.ex_opcode_i     = op;
    bus.ex_alu_out_i    = alu;
    bus.ex_alu_flag_i   = flg;
    bus.ex_store_data_i = sd;
    bus.ex_rd_i         = rd;
    bus.ex_regwrite_i   = rw;
    bus.ex_memread_i    = mr;
    bus.ex_memwrite_i   = mw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, OpAdd, 16'h0, 3'b000, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_vld", {15'd0, bus.mem_vld_o}, 16'd0);
    chk("rst_flag", {13'd0, flag_o}, 16'd0);
    chk("rst_halt", {15'd0, halted_o}, 16'd0);
    tick();
    rst_n = 1'b1;

    // ADD writes all flags
    drive(1'b1, OpAdd, 16'h1234, 3'b110, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0);
    chk("add_fwd", {13'd0, flag_fwd_o}, 16'h6);
    tick();
    chk("add_flag", {13'd0, flag_o}, 16'h6);
    chk("add_vld", {15'd0, bus.mem_vld_o}, 16'd1);
    chk("add_alu", bus.mem_alu_out_o, 16'h1234);
    chk("add_rd", {12'd0, bus.mem_rd_o}, 16'd3);
    chk("add_rw", {15'd0, bus.mem_regwrite_o}, 16'd1);

    // XOR writes Z only
    drive(1'b1, OpXor, 16'h00FF, 3'b001, 16'h0, 4'd4, 1'b1, 1'b0, 1'b0);
    chk("xor_fwd", {13'd0, flag_fwd_o}, 16'h7);
    tick();
    chk("xor_flag", {13'd0, flag_o}, 16'h7);

    // RED / PADDSB never touch flags
    drive(1'b1, OpRed, 16'h0011, 3'b000, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("red_fwd", {13'd0, flag_fwd_o}, 16'h7);
    tick();
    chk("red_flag", {13'd0, flag_o}, 16'h7);
    drive(1'b1, OpPaddsb, 16'h0022, 3'b010, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("paddsb_flag", {13'd0, flag_o}, 16'h7);
    chk("paddsb_alu", bus.mem_alu_out_o, 16'h0022);

    // SUB clears all, ADD sets all, SRA clears only Z
    drive(1'b1, OpSub, 16'h0, 3'b000, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("sub_flag", {13'd0, flag_o}, 16'h0);
    drive(1'b1, OpAdd, 16'h8000, 3'b111, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, OpSra, 16'hBEEF, 3'b000, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0);
    chk("sra_fwd", {13'd0, flag_fwd_o}, 16'h6);
    tick();
    chk("sra_flag", {13'd0, flag_o}, 16'h6);

    // Stall three cycles with changing inputs
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OpAdd, 16'hA000 + 16'(i), 3'b001, 16'h0, 4'd7, 1'b0, 1'b1, 1'b1);
      chk("stall_fwd", {13'd0, flag_fwd_o}, 16'h6);
      tick();
      chk("stall_alu", bus.mem_alu_out_o, 16'hBEEF);
      chk("stall_flag", {13'd0, flag_o}, 16'h6);
      chk("stall_vld", {15'd0, bus.mem_vld_o}, 16'd1);
      chk("stall_rd", {12'd0, bus.mem_rd_o}, 16'd2);
    end

    // Stall plus flush inserts a bubble
    flush_i = 1'b1;
    drive(1'b1, OpAdd, 16'h1111, 3'b001, 16'h0, 4'd7, 1'b1, 1'b1, 1'b1);
    tick();
    chk("flush_vld", {15'd0, bus.mem_vld_o}, 16'd0);
    chk("flush_ctl", {13'd0, bus.mem_regwrite_o, bus.mem_memread_o, bus.mem_memwrite_o},
        16'd0);
    chk("flush_flag", {13'd0, flag_o}, 16'h6);
    stall_i = 1'b0;
    flush_i = 1'b0;

    // LW to r0 must not write back
    drive(1'b1, OpLw, 16'h0040, 3'b111, 16'h0, 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("lw0_rw", {15'd0, bus.mem_regwrite_o}, 16'd0);
    chk("lw0_mr", {15'd0, bus.mem_memread_o}, 16'd1);
    chk("lw0_flag", {13'd0, flag_o}, 16'h6);

    // SW
    drive(1'b1, OpSw, 16'h0042, 3'b000, 16'hCAFE, 4'd5, 1'b0, 1'b0, 1'b1);
    tick();
    chk("sw_mw", {15'd0, bus.mem_memwrite_o}, 16'd1);
    chk("sw_sd", bus.mem_store_data_o, 16'hCAFE);

    // HLT while stalled or flushed leaves state alone
    stall_i = 1'b1;
    drive(1'b1, OpHlt, 16'h0, 3'b111, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("hlt_stall", {15'd0, halted_o}, 16'd0);
    stall_i = 1'b0;
    flush_i = 1'b1;
    tick();
    chk("hlt_flush", {15'd0, halted_o}, 16'd0);
    flush_i = 1'b0;

    // Real HLT
    drive(1'b1, OpHlt, 16'h0, 3'b111, 16'h0, 4'd2, 1'b1, 1'b1, 1'b1);
    tick();
    chk("hlt_vld", {15'd0, bus.mem_vld_o}, 16'd1);
    chk("hlt_halt", {15'd0, halted_o}, 16'd1);
    chk("hlt_ctl", {13'd0, bus.mem_regwrite_o, bus.mem_memread_o, bus.mem_memwrite_o},
        16'd0);
    chk("hlt_flag", {13'd0, flag_o}, 16'h6);

    // After halt everything is a bubble
    drive(1'b1, OpAdd, 16'h7777, 3'b001, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0);
    chk("halt_fwd", {13'd0, flag_fwd_o}, 16'h6);
    tick();
    chk("halt_vld", {15'd0, bus.mem_vld_o}, 16'd0);
    chk("halt_flag", {13'd0, flag_o}, 16'h6);
    chk("halt_rw", {15'd0, bus.mem_regwrite_o}, 16'd0);
    chk("halt_sticky", {15'd0, halted_o}, 16'd1);

    // Asynchronous reset away from any edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_halt", {15'd0, halted_o}, 16'd0);
    chk("areset_flag", {13'd0, flag_o}, 16'd0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, OpAdd, 16'h5555, 3'b100, 16'h0, 4'd6, 1'b1, 1'b0, 1'b0);
    tick();
    chk("post_rst_vld", {15'd0, bus.mem_vld_o}, 16'd1);
    chk("post_rst_alu", bus.mem_alu_out_o, 16'h5555);
    chk("post_rst_flag", {13'd0, flag_o}, 16'h4);

    // Reset mid-stall with a valid slot held
    stall_i = 1'b1;
    drive(1'b1, OpLw, 16'h9999, 3'b000, 16'h1234, 4'd9, 1'b1, 1'b1, 1'b0);
    tick();
    chk("pre_rst_vld", {15'd0, bus.mem_vld_o}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {15'd0, bus.mem_vld_o}, 16'd0);
    chk("mid_rst_alu", bus.mem_alu_out_o, 16'd0);
    chk("mid_rst_rd", {12'd0, bus.mem_rd_o}, 16'd0);
    chk("mid_rst_rw", {15'd0, bus.mem_regwrite_o}, 16'd0);
    chk("mid_rst_flag", {13'd0, flag_o}, 16'd0);
    #1;
    rst_n = 1'b1;
    stall_i = 1'b0;
    drive(1'b1, OpSub, 16'h0ABC, 3'b011, 16'h0, 4'd8, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rel_vld", {15'd0, bus.mem_vld_o}, 16'd1);
    chk("rel_alu", bus.mem_alu_out_o, 16'h0ABC);
    chk("rel_rd", {12'd0, bus.mem_rd_o}, 16'd8);
    chk("rel_flag", {13'd0, flag_o}, 16'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register and flag register sitting directly downstream of the EX-stage ALU in the 16-bit 5-stage processor. Each cycle it captures the ALU result, the ALU flags and the EX control bundle into the EX/MEM register. It commits N/V/Z to the architectural flag register under per-opcode write restrictions and forwards the next flag value to ID for branch resolution. It also tracks a sticky RUN/HALT state once HLT retires from EX.

## Interface
Parameters:
- DW, 16, datapath width
- RW, 4, register-index width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold EX/MEM contents and flags
- flush_i  in  1  replace the incoming EX instruction with a bubble
- ex_vld_i  in  1  EX holds a real instruction
- ex_opcode_i  in  4  EX opcode
- ex_alu_out_i  in  DW  ALU result
- ex_alu_flag_i  in  3  ALU flags {N,V,Z}
- ex_store_data_i  in  DW  rt value for SW
- ex_rd_i  in  RW  destination register
- ex_regwrite_i, ex_memread_i, ex_memwrite_i  in  1 each  control bits
- mem_vld_o  out  1  MEM holds a real instruction
- mem_alu_out_o, mem_store_data_o  out  DW each  registered copies
- mem_rd_o  out  RW  registered destination
- mem_regwrite_o, mem_memread_o, mem_memwrite_o  out  1 each  registered control; all forced 0 when mem_vld_o=0
- flag_o  out  3  architectural flags {N,V,Z}
- flag_fwd_o  out  3  flags as they will be after this edge (combinational)
- halted_o  out  1  sticky halt indication

## Operation
- Capture condition: cap = ex_vld_i & ~flush_i & ~stall_i & (state==RUN).
- On each edge with ~stall_i or flush_i:
  - mem_vld_o <= cap.
  - Datapath fields are loaded from the EX inputs.
  - Control bits are loaded as EX bit & cap.
  - mem_regwrite_o is additionally forced 0 when ex_rd_i==0.
- Flag write mask by opcode:
  - 0000 ADD, 0001 SUB: write N,V,Z.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: write Z only.
  - All other opcodes: no flag write.
- Flags are written only when cap=1. Bits not in the mask keep their value.
- flag_fwd_o equals the value flag_o will hold after the next edge. When no flag write occurs, flag_fwd_o = flag_o.
- State machine, RUN→HALT:
  - Transition when cap=1 and opcode=1111 (HLT).
  - The HLT itself is captured with mem_vld_o=1, regwrite=0 and mem ops 0.
  - In HALT, cap is 0, so all further EX instructions become bubbles and flags freeze.
  - HALT exits only on reset.
- halted_o = (state==HALT).

## Timing
- Latency: 1 cycle from EX inputs to mem_* outputs and flag_o.
- flag_fwd_o has 0-cycle latency, combinational from EX inputs.
- Reset: all mem_* outputs = 0, flag_o = 3'b000, state = RUN, halted_o = 0. Reset acts immediately, including mid-stall.
- stall_i=1, flush_i=0: every register holds and no flag write occurs.
- flush_i=1: bubble inserted regardless of stall_i, so flush has priority. Flags are not written.
- A HLT arriving while stalled or flushed does not change state.
- Back-to-back flag writers each update on their own edge. A Z-only writer following an ADD keeps the N/V written by the ADD.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams (ADD…HLT)
  - flag bit indices: N=2, V=1, Z=0
  - function flag_mask(opcode) returning 3 bits
  - state encoding RUN/HALT
- One sub-module `flag_reg`:
  - 3-bit register with per-bit write mask and async active-low reset
  - outputs both the current value and the next-state (forward) value

## Test plan
- Reset then ADD with ex_alu_flag_i=3'b110, vld=1 → next cycle flag_o=3'b110, mem_vld_o=1, mem_alu_out_o=ex_alu_out_i.
- flag_o=3'b110, then XOR with flag 3'b001 → flag_fwd_o=3'b111 the same cycle; flag_o=3'b111 after the edge. RED/PADDSB with any flags → flag_o unchanged.
- stall_i=1 for 3 cycles with changing EX inputs → mem_* and flag_o frozen. stall_i=flush_i=1 → mem_vld_o=0, all control 0, flags unchanged.
- LW to rd=0 with regwrite=1 → mem_regwrite_o=0, mem_memread_o=1.
- HLT valid → mem_vld_o=1, halted_o=1 next cycle. Following ADD with vld=1 → mem_vld_o=0, flags unchanged. Assert rst_n=0 → halted_o=0 immediately.
- rst_n pulled low mid-stream with mem_vld_o=1 → all outputs 0 asynchronously. First valid instruction after release captured normally.
